// File: rtl/reg16_write_arbiter.sv
// Round-robin write-port arbiter for a shared register, with registered one-hot grant
// and a lock option that lets one requester take up to MAX_HOLD back-to-back writes.
module reg16_write_arbiter #(
    parameter int W        = 16,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [NREQ*W-1:0]   din_bus,
    output logic [NREQ-1:0]     gnt,
    output logic                reg_we,
    output logic [W-1:0]        reg_din,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        LOCK  = 2'd2
    } state_t;

    localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW     = $clog2(MAX_HOLD + 1);
    localparam int LAST_I = NREQ - 1;
    localparam logic [IW-1:0] LAST_RST   = LAST_I[IW-1:0];
    localparam logic [HW-1:0] MAX_HOLD_C = MAX_HOLD[HW-1:0];

    state_t          state, state_n;
    logic [IW-1:0]   last, last_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0] gnt_n;
    logic [W-1:0]    din_n;
    logic            we_n;
    logic            busy_n;

    logic [NREQ-1:0] last_oh;
    logic [NREQ-1:0] cand;
    logic            do_arb;
    logic            found;
    logic [IW-1:0]   win;
    int              idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= LAST_RST;
            hold_cnt <= '0;
            gnt      <= '0;
            reg_din  <= '0;
            reg_we   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            reg_din  <= din_n;
            reg_we   <= we_n;
            busy     <= busy_n;
        end
    end

    assign fsm_state = state;

    always_comb begin
        state_n = state;
        last_n  = last;
        hold_n  = hold_cnt;
        gnt_n   = '0;
        din_n   = '0;
        we_n    = 1'b0;
        do_arb  = 1'b0;
        last_oh = '0;
        last_oh[last] = 1'b1;
        cand    = req;

        // In GRANT/LOCK, "last" is the current owner; it is masked unless it keeps its lock.
        case (state)
            IDLE: begin
                do_arb = 1'b1;
                cand   = req;
            end
            GRANT: begin
                do_arb = 1'b1;
                cand   = req & ~last_oh;
            end
            LOCK: begin
                if (req[last] && lock[last] && (hold_cnt < MAX_HOLD_C)) begin
                    gnt_n  = last_oh;
                    din_n  = din_bus[int'(last)*W +: W];
                    we_n   = 1'b1;
                    hold_n = hold_cnt + 1'b1;
                end else if (req[last] && !lock[last]) begin
                    gnt_n   = last_oh;
                    din_n   = din_bus[int'(last)*W +: W];
                    we_n    = 1'b1;
                    hold_n  = '0;
                    state_n = GRANT;
                end else begin
                    do_arb = 1'b1;
                    cand   = req & ~last_oh;
                end
            end
            default: begin
                do_arb = 1'b1;
                cand   = req;
            end
        endcase

        // Search starts just after the previous winner, so it ends up lowest priority.
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end

        if (do_arb) begin
            if (found) begin
                gnt_n      = '0;
                gnt_n[win] = 1'b1;
                din_n      = din_bus[int'(win)*W +: W];
                we_n       = 1'b1;
                last_n     = win;
                if (lock[win]) begin
                    state_n = LOCK;
                    hold_n  = {{(HW-1){1'b0}}, 1'b1};
                end else begin
                    state_n = GRANT;
                    hold_n  = '0;
                end
            end else begin
                state_n = IDLE;
                hold_n  = '0;
            end
        end

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_reg16_write_arbiter.sv
// Directed bench for reg16_write_arbiter: expected writes are queued as stimulus is
// driven and compared against gnt/reg_din in the cycle they should appear.
module tb_reg16_write_arbiter;

    localparam int W        = 16;
    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 4;
    localparam int SBW      = NREQ + W;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*W-1:0] din_bus;
    logic [NREQ-1:0]   gnt;
    logic              reg_we;
    logic [W-1:0]      reg_din;
    logic              busy;
    logic [1:0]        fsm_state;

    logic [W-1:0]      reg_q;
    logic [SBW-1:0]    exp_q[$];
    logic [W-1:0]      dv[NREQ];
    int                tests;
    int                fails;

    reg16_write_arbiter #(.W(W), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .din_bus   (din_bus),
        .gnt       (gnt),
        .reg_we    (reg_we),
        .reg_din   (reg_din),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // downstream register16b model
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) reg_q <= '0;
        else if (reg_we) reg_q <= reg_din;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = 4'(4'b0001 << i);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input int i, input logic [W-1:0] v);
        din_bus[i*W +: W] = v;
    endtask

    task automatic push(input int i, input logic [W-1:0] v);
        exp_q.push_back({oh(i), v});
    endtask

    // one clock: sample outputs 1 time unit after the edge and score them
    task automatic cycle();
        @(posedge clk);
        #1;
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
        check("we_vs_gnt", 32'(reg_we), 32'(|gnt));
        if (!reg_we) check("din_zero_idle", 32'(reg_din), 32'd0);
        if (reg_we) begin
            if (exp_q.size() == 0) check("spurious_write", 32'({gnt, reg_din}), 32'd0);
            else check("sb_grant", 32'({gnt, reg_din}), 32'(exp_q.pop_front()));
        end else if (exp_q.size() != 0) begin
            check("missing_write", 32'({gnt, reg_din}), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        reset   = 1'b0;
        req     = 4'b1111;
        lock    = '0;
        din_bus = '0;
        for (int i = 0; i < NREQ; i++) begin
            dv[i] = W'($urandom_range(0, 65535));
            set_din(i, dv[i]);
        end

        // 1: reset holds outputs low even with all requests up
        cycle();
        cycle();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_din", 32'(reg_din), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        push(0, dv[0]);
        cycle();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_state_grant", 32'(fsm_state), 32'd1);

        // 2: all four requesting, each acks by a one-cycle drop -> 0,1,2,3,0
        for (int j = 1; j <= NREQ; j++) begin
            req = 4'b1111;
            req[(j - 1) % NREQ] = 1'b0;
            push(j % NREQ, dv[j % NREQ]);
            cycle();
            check("t2_reg_q", 32'(reg_q), 32'(dv[(j - 1) % NREQ]));
        end
        req = '0;
        cycle();
        check_idle("t2_end");

        // 3: single non-locked request
        req = 4'b0100;
        set_din(2, 16'h00AA);
        push(2, 16'h00AA);
        cycle();
        req = '0;
        cycle();
        check_idle("t3_end");
        check("t3_reg_q", 32'(reg_q), 32'h00AA);

        // 4: locked burst by requester 1 with requester 3 waiting; forced rotation after 4
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        req  = 4'b1010;
        lock = 4'b0010;
        set_din(3, 16'h3333);
        for (int d = 1; d <= MAX_HOLD; d++) begin
            set_din(1, W'(d));
            push(1, W'(d));
            cycle();
            if (d == 1) check("t4_state_lock", 32'(fsm_state), 32'd2);
        end
        set_din(1, 16'd5);
        push(3, 16'h3333);
        cycle();
        check("t4_reg_q", 32'(reg_q), 32'd4);
        req = 4'b0010;
        push(1, 16'd5);
        cycle();

        // 5: asynchronous reset mid-LOCK (hold_cnt=2)
        set_din(1, 16'd6);
        push(1, 16'd6);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'd0);
        check("t5_async_we", 32'(reg_we), 32'd0);
        check("t5_async_din", 32'(reg_din), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        cycle();
        reset = 1'b1;
        req  = 4'b1001;
        lock = '0;
        set_din(0, dv[0]);
        push(0, dv[0]);
        cycle();
        req = '0;
        cycle();
        check_idle("t5_end");

        // 6: requester 0 locks, then drops lock on its second write
        req  = 4'b0001;
        lock = 4'b0001;
        set_din(0, 16'h00A1);
        push(0, 16'h00A1);
        cycle();
        lock = '0;
        set_din(0, 16'h00A2);
        push(0, 16'h00A2);
        cycle();
        req = '0;
        cycle();
        check_idle("t6_end");
        check("t6_reg_q", 32'(reg_q), 32'h00A2);

        // 7: sole locked requester is forced out for one cycle after MAX_HOLD writes
        req  = 4'b0001;
        lock = 4'b0001;
        for (int k = 0; k < MAX_HOLD; k++) begin
            set_din(0, W'(16'h00B0 + k));
            push(0, W'(16'h00B0 + k));
            cycle();
        end
        set_din(0, 16'h00B4);
        cycle();
        check_idle("t7_gap");
        push(0, 16'h00B4);
        cycle();
        req  = '0;
        lock = '0;
        cycle();
        check_idle("t7_end");
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
